// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    // Which requester owns the read data returning in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    // Arbitration mode encoding on cfg_rr.
    localparam logic ARB_PRIO = 1'b0;
    localparam logic ARB_RR   = 1'b1;

    // Width of the starvation wait counters.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles a requester has been kept waiting.
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [WAIT_W-1:0] MAX_VAL = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] count_r;

    // Count lost cycles, clear on grant or withdrawn request, hold at MAX_VAL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {WAIT_W{1'b0}};
        end else if (clr) begin
            count_r <= {WAIT_W{1'b0}};
        end else if (inc && (count_r != MAX_VAL)) begin
            count_r <= count_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign at_max = (count_r == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between the CPU and the debug/DMA port,
// granting at most one access per cycle and steering read data back to
// whichever requester issued the read in the previous cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_rr,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_write,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout
);

    owner_t owner_r;
    owner_t owner_next_s;
    owner_t last_gnt_r;
    logic   c_gnt_s;
    logic   d_gnt_s;
    logic   c_at_max_s;
    logic   d_at_max_s;

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_c_wait (
        .clk    (clk),
        .reset  (reset),
        .inc    (c_req & ~c_gnt_s),
        .clr    (~c_req | c_gnt_s),
        .at_max (c_at_max_s)
    );

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_d_wait (
        .clk    (clk),
        .reset  (reset),
        .inc    (d_req & ~d_gnt_s),
        .clr    (~d_req | d_gnt_s),
        .at_max (d_at_max_s)
    );

    // Grant decision: lone requester wins; on contention a starved side wins,
    // otherwise CPU priority or alternation against last_gnt by cfg_rr.
    always_comb begin
        c_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!reset) begin
            c_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (c_req && !d_req) begin
            c_gnt_s = 1'b1;
        end else if (!c_req && d_req) begin
            d_gnt_s = 1'b1;
        end else if (c_req && d_req) begin
            if (c_at_max_s) begin
                c_gnt_s = 1'b1;
            end else if (d_at_max_s) begin
                d_gnt_s = 1'b1;
            end else if ((cfg_rr == ARB_RR) && (last_gnt_r == OWN_CPU)) begin
                d_gnt_s = 1'b1;
            end else begin
                c_gnt_s = 1'b1;
            end
        end else begin
            c_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Owner of next cycle's read data: a granted read, or nobody.
    always_comb begin
        owner_next_s = OWN_NONE;
        if (c_gnt_s && !c_we) begin
            owner_next_s = OWN_CPU;
        end else if (d_gnt_s && !d_we) begin
            owner_next_s = OWN_DBG;
        end else begin
            owner_next_s = OWN_NONE;
        end
    end

    // Read-owner pipeline stage; reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= owner_next_s;
        end
    end

    // Remember the most recent winner; starts at debug so the CPU wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt_r <= OWN_DBG;
        end else if (c_gnt_s) begin
            last_gnt_r <= OWN_CPU;
        end else if (d_gnt_s) begin
            last_gnt_r <= OWN_DBG;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign c_gnt    = c_gnt_s;
    assign d_gnt    = d_gnt_s;
    assign c_rvalid = (owner_r == OWN_CPU);
    assign d_rvalid = (owner_r == OWN_DBG);
    assign c_rdata  = c_rvalid ? m_dout : {DATA_W{1'b0}};
    assign d_rdata  = d_rvalid ? m_dout : {DATA_W{1'b0}};

    // Idle cycles keep the CPU address on the bus so fetch addresses stay put.
    assign m_addr  = !reset  ? {ADDR_W{1'b0}} : (d_gnt_s ? d_addr  : c_addr);
    assign m_din   = !reset  ? {DATA_W{1'b0}} : (d_gnt_s ? d_wdata : c_wdata);
    assign m_write = (c_gnt_s & c_we) | (d_gnt_s & d_we);

endmodule
